// File: rtl/led_key_driver.sv
// Command-driven generator of active-low KEY0/KEY1/KEY2 press waveforms for the
// LED thermometer counter, with a mod-10 model of the counter value and its LEDs.
module led_key_driver #(
    parameter int PRESS_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_arg,
    output logic       KEY0,
    output logic       KEY1,
    output logic       KEY2,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] pos,
    output logic [8:0] exp_ledg
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAN  = 3'd1,
        PRESS = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SEL_CLR    = 2'd0;
    localparam logic [1:0] SEL_INC    = 2'd1;
    localparam logic [1:0] SEL_DEC    = 2'd2;
    localparam logic [7:0] PRESS_LAST = 8'(PRESS_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    function automatic logic [8:0] therm(input logic [3:0] v);
        logic [8:0] t;
        t = 9'd0;
        for (int i = 0; i < 9; i++) begin
            t[i] = (4'(i) < v) ? 1'b1 : 1'b0;
        end
        return t;
    endfunction

    function automatic logic [3:0] step(input logic [1:0] sel, input logic [3:0] p);
        logic [3:0] r;
        case (sel)
            SEL_INC: r = (p == 4'd9) ? 4'd0 : p + 4'd1;
            SEL_DEC: r = (p == 4'd0) ? 4'd9 : p - 4'd1;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    state_t     state_r, state_s;
    logic [1:0] op_r;
    logic [3:0] arg_r;
    logic [1:0] sel_r, sel_s;
    logic [7:0] presses_r, presses_s;
    logic [7:0] phase_r, phase_s;
    logic [3:0] pos_r, pos_s;
    logic [2:0] keys_r, keys_s;
    logic       done_r, done_s;
    logic       err_r, err_s;
    logic       ready_r, busy_r;
    logic [8:0] ledg_r;
    logic [4:0] diff_s;
    logic [1:0] plan_sel_s;
    logic [7:0] plan_cnt_s;
    logic       plan_bad_s;

    // Press plan from the latched command; SET takes the shorter way round the ring, ties go up.
    always_comb begin
        diff_s = {1'b0, arg_r} + 5'd10 - {1'b0, pos_r};
        if (diff_s >= 5'd10) begin
            diff_s = diff_s - 5'd10;
        end else begin
            diff_s = diff_s;
        end
        plan_bad_s = 1'b0;
        plan_sel_s = SEL_INC;
        plan_cnt_s = 8'd0;
        case (op_r)
            2'b00: begin
                if (arg_r > 4'd9) begin
                    plan_bad_s = 1'b1;
                end else if (diff_s == 5'd0) begin
                    plan_cnt_s = 8'd0;
                end else if (diff_s <= 5'd5) begin
                    plan_sel_s = SEL_INC;
                    plan_cnt_s = {3'd0, diff_s};
                end else begin
                    plan_sel_s = SEL_DEC;
                    plan_cnt_s = {3'd0, 5'd10 - diff_s};
                end
            end
            2'b01: begin
                plan_sel_s = SEL_INC;
                plan_cnt_s = {4'd0, arg_r};
            end
            2'b10: begin
                plan_sel_s = SEL_DEC;
                plan_cnt_s = {4'd0, arg_r};
            end
            default: begin
                plan_sel_s = SEL_CLR;
                plan_cnt_s = 8'd1;
            end
        endcase
    end

    // Next-state logic; pos steps at the end of each press phase.
    always_comb begin
        state_s   = state_r;
        sel_s     = sel_r;
        presses_s = presses_r;
        phase_s   = phase_r;
        pos_s     = pos_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_s = PLAN;
                end else begin
                    state_s = IDLE;
                end
            end
            PLAN: begin
                phase_s = 8'd0;
                if (plan_bad_s) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (plan_cnt_s != 8'd0) begin
                    sel_s     = plan_sel_s;
                    presses_s = plan_cnt_s;
                    state_s   = PRESS;
                end else begin
                    done_s  = 1'b1;
                    state_s = DONE;
                end
            end
            PRESS: begin
                if (phase_r == PRESS_LAST) begin
                    phase_s   = 8'd0;
                    pos_s     = step(sel_r, pos_r);
                    presses_s = presses_r - 8'd1;
                    state_s   = GAP;
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end
            GAP: begin
                if (phase_r == GAP_LAST) begin
                    phase_s = 8'd0;
                    if (presses_r != 8'd0) begin
                        state_s = PRESS;
                    end else begin
                        done_s  = 1'b1;
                        state_s = DONE;
                    end
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Key levels follow the next state so only the selected key is low, and only in PRESS.
    always_comb begin
        keys_s = 3'b111;
        if (state_s == PRESS) begin
            case (sel_s)
                SEL_CLR: keys_s = 3'b110;
                SEL_INC: keys_s = 3'b101;
                SEL_DEC: keys_s = 3'b011;
                default: keys_s = 3'b111;
            endcase
        end else begin
            keys_s = 3'b111;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            op_r      <= 2'd0;
            arg_r     <= 4'd0;
            sel_r     <= SEL_INC;
            presses_r <= 8'd0;
            phase_r   <= 8'd0;
            pos_r     <= 4'd0;
            keys_r    <= 3'b111;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            ledg_r    <= 9'd0;
        end else begin
            if ((state_r == IDLE) && cmd_valid) begin
                op_r  <= cmd_op;
                arg_r <= cmd_arg;
            end
            state_r   <= state_s;
            sel_r     <= sel_s;
            presses_r <= presses_s;
            phase_r   <= phase_s;
            pos_r     <= pos_s;
            keys_r    <= keys_s;
            done_r    <= done_s;
            err_r     <= err_s;
            ready_r   <= (state_s == IDLE);
            busy_r    <= (state_s != IDLE);
            ledg_r    <= therm(pos_s);
        end
    end

    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign pos       = pos_r;
    assign exp_ledg  = ledg_r;
    assign KEY0      = keys_r[0];
    assign KEY1      = keys_r[1];
    assign KEY2      = keys_r[2];
endmodule
